// File: rtl/div_radix2.sv
// div_radix2 -- iterative radix-2 restoring divider (EX-stage divide responder).
//
// One quotient bit per clock on a {rem, dividend} shift register. Signed
// operands are reduced to magnitudes on entry and the signs are reapplied in
// the END state. The quotient is negated when the operand signs differ, and
// the remainder takes the sign of the dividend.
//
// Ports:
//   clk, rst       posedge clock, synchronous active-high reset
//   flush, annul_i abort any operation (next state IDLE, no ready pulse)
//   signed_div_i   1 = signed (DIV), 0 = unsigned (DIVU); sampled in IDLE
//   opdata1_i/2_i  dividend / divisor, sampled in IDLE only
//   start_i        level request, held by the requester until ready_o
//   result_o       {remainder, quotient}, registered, held until next result
//   ready_o        registered one-cycle pulse marking result_o valid
//
// Optional feature: define DIV_EARLY_OUT_EN to finish in two cycles whenever
// |dividend| < |divisor| (quotient 0, remainder = dividend).
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e             state_q,  state_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH:0]   sr_q,     sr_d;      // {rem[WIDTH:0], dividend/quotient[WIDTH-1:0]}
  logic [WIDTH-1:0]   dvsr_q,   dvsr_d;    // |divisor|
  logic               negq_q,   negq_d;    // negate quotient at END
  logic               negr_q,   negr_d;    // negate remainder at END
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q,  ready_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH+1:0] shifted;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   quot_raw, rem_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = 1'b0;

    abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The top bit of the register is always 0 (rem < divisor), so the extra
    // bit here only widens the subtract so its MSB is a clean borrow flag.
    shifted  = {sr_q, 1'b0};
    trial    = shifted[2*WIDTH+1:WIDTH] - {2'b00, dvsr_q};
    quot_raw = sr_q[WIDTH-1:0];
    rem_raw  = sr_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i && !flush) begin
          cnt_d  = '0;
          negq_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d = signed_div_i & opdata1_i[WIDTH-1];
          dvsr_d = abs_b;
          if (opdata2_i == '0) begin
            sr_d    = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_DIVZERO;
`ifdef DIV_EARLY_OUT_EN
          end else if (abs_a < abs_b) begin
            // Result is known already: preload rem=|a|, quot=0 and take the
            // one-cycle bypass path; END re-signs the remainder back to the
            // original dividend.
            sr_d    = {1'b0, abs_a, {WIDTH{1'b0}}};
            state_d = S_DIVZERO;
`endif
          end else begin
            sr_d    = {{(WIDTH+1){1'b0}}, abs_a};
            state_d = S_ON;
          end
        end
      end
      // One-cycle bypass to END; sr_q already holds the final raw result.
      S_DIVZERO: state_d = S_END;
      S_ON: begin
        sr_d = shifted[2*WIDTH:0];
        if (!trial[WIDTH+1]) begin
          sr_d[2*WIDTH:WIDTH] = trial[WIDTH:0];
          sr_d[0]             = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = S_END;
      end
      S_END: begin
        ready_d  = 1'b1;
        result_d = {(negr_q ? -rem_raw : rem_raw), (negq_q ? -quot_raw : quot_raw)};
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats everything, including the END pulse.
    if (flush || annul_i) begin
      state_d  = S_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
